// File: rtl/semi_pkg.sv
// Shared constants, FSM state type and pixel mapping for the semigraphics pixel shifter.
package semi_pkg;

  localparam int CHAR_PIXELS = 8;
  localparam int COLOUR_W    = 4;
  localparam int BITCNT_W    = $clog2(CHAR_PIXELS) + 1;

  localparam logic [COLOUR_W-1:0] COLOUR_BLACK = 4'h0;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // A set pattern bit shows the cell foreground, a clear bit shows black.
  function automatic logic [COLOUR_W-1:0] pixel_colour(input logic                pat_bit,
                                                       input logic [COLOUR_W-1:0] fg);
    return pat_bit ? fg : COLOUR_BLACK;
  endfunction

endpackage

// File: rtl/semi_pixel_divider.sv
// Pixel-rate divider: counts 0..PIXEL_DIV-1 while active, held at 0 in blanking.
// tick_o is combinational and high on the last count of each pixel period.
module semi_pixel_divider #(
  parameter int PIXEL_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic active_i,
  output logic tick_o
);

  localparam int CNT_W = (PIXEL_DIV > 1) ? $clog2(PIXEL_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PIXEL_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!active_i) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = active_i && (cnt_q == CNT_MAX);

endmodule

// File: rtl/semi_pixel_shifter.sv
// Serialises one 8-bit semigraphics row per cell into colour indices, MSB first, with a
// one-character holding register (LoadReady = holding empty) and a saturating underrun count.
module semi_pixel_shifter
  import semi_pkg::*;
#(
  parameter int PIXEL_DIV  = 2,
  parameter int UNDERRUN_W = 8
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Active,
  input  logic [CHAR_PIXELS-1:0] SData,
  input  logic [COLOUR_W-1:0]    SColour,
  input  logic                   LoadValid,
  output logic                   LoadReady,
  output logic [COLOUR_W-1:0]    PixelColour,
  output logic                   PixelValid,
  output logic                   Underrun,
  output logic [UNDERRUN_W-1:0]  UnderrunCount
);

  localparam logic [BITCNT_W-1:0] BITCNT_FULL = BITCNT_W'(CHAR_PIXELS);

  logic tick;

  state_e                 state_q, state_d;
  logic [CHAR_PIXELS-1:0] hold_dat_q, hold_dat_d;
  logic [COLOUR_W-1:0]    hold_col_q, hold_col_d;
  logic                   hold_full_q, hold_full_d;
  logic [CHAR_PIXELS-1:0] shift_q, shift_d;
  logic [COLOUR_W-1:0]    fg_q, fg_d;
  logic [BITCNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [COLOUR_W-1:0]    pix_col_q, pix_col_d;
  logic                   pix_vld_q, pix_vld_d;
  logic                   underrun_q, underrun_d;
  logic [UNDERRUN_W-1:0]  ucnt_q, ucnt_d;

  logic load_acc;
  logic char_done;
  logic xfer;
  logic underrun_ev;

  semi_pixel_divider #(
    .PIXEL_DIV (PIXEL_DIV)
  ) u_div (
    .clk_i    (Clk),
    .rst_i    (Reset),
    .active_i (Active),
    .tick_o   (tick)
  );

  // Transfer and load are mutually exclusive: transfer needs a full holding register.
  assign load_acc    = LoadValid && !hold_full_q;
  assign char_done   = (bit_cnt_q == BITCNT_FULL);
  assign xfer        = tick && hold_full_q && ((state_q == IDLE) || char_done);
  assign underrun_ev = tick && !hold_full_q && (state_q == SHIFT) && char_done;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!Active) begin
      state_d = IDLE;
    end else if (xfer) begin
      state_d = SHIFT;
    end else if (underrun_ev) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    hold_dat_d  = hold_dat_q;
    hold_col_d  = hold_col_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    fg_d        = fg_q;
    bit_cnt_d   = bit_cnt_q;
    pix_col_d   = pix_col_q;
    pix_vld_d   = pix_vld_q;
    underrun_d  = 1'b0;
    ucnt_d      = ucnt_q;

    if (load_acc) begin
      hold_dat_d  = SData;
      hold_col_d  = SColour;
      hold_full_d = 1'b1;
    end

    if (!Active) begin
      // Blanking discards the character in flight but keeps the prefetched one.
      shift_d   = '0;
      bit_cnt_d = '0;
      pix_col_d = COLOUR_BLACK;
      pix_vld_d = 1'b0;
    end else if (xfer) begin
      hold_full_d = 1'b0;
      shift_d     = {hold_dat_q[CHAR_PIXELS-2:0], 1'b0};
      fg_d        = hold_col_q;
      bit_cnt_d   = BITCNT_W'(1);
      pix_col_d   = pixel_colour(hold_dat_q[CHAR_PIXELS-1], hold_col_q);
      pix_vld_d   = 1'b1;
    end else if (underrun_ev) begin
      underrun_d = 1'b1;
      if (ucnt_q != '1) begin
        ucnt_d = ucnt_q + 1'b1;
      end
      shift_d   = '0;
      bit_cnt_d = '0;
      pix_col_d = COLOUR_BLACK;
      pix_vld_d = 1'b0;
    end else if (tick && (state_q == SHIFT)) begin
      // shift_q is kept pre-shifted, so its MSB is always the next pixel.
      shift_d   = {shift_q[CHAR_PIXELS-2:0], 1'b0};
      bit_cnt_d = bit_cnt_q + 1'b1;
      pix_col_d = pixel_colour(shift_q[CHAR_PIXELS-1], fg_q);
    end else if (tick) begin
      pix_col_d = COLOUR_BLACK;
      pix_vld_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hold_dat_q  <= '0;
      hold_col_q  <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      fg_q        <= '0;
      bit_cnt_q   <= '0;
      pix_col_q   <= COLOUR_BLACK;
      pix_vld_q   <= 1'b0;
      underrun_q  <= 1'b0;
      ucnt_q      <= '0;
    end else begin
      hold_dat_q  <= hold_dat_d;
      hold_col_q  <= hold_col_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      fg_q        <= fg_d;
      bit_cnt_q   <= bit_cnt_d;
      pix_col_q   <= pix_col_d;
      pix_vld_q   <= pix_vld_d;
      underrun_q  <= underrun_d;
      ucnt_q      <= ucnt_d;
    end
  end

  assign LoadReady     = !hold_full_q;
  assign PixelColour   = pix_col_q;
  assign PixelValid    = pix_vld_q;
  assign Underrun      = underrun_q;
  assign UnderrunCount = ucnt_q;

endmodule

// File: tb/tb_semi_pixel_shifter.sv
// Bench for semi_pixel_shifter: reset, table-driven single character, directed corner sequences,
// randomized traffic against a pixel-index reference model, and counter saturation on a second instance.
module tb_semi_pixel_shifter;

  localparam int PD = 2;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Active = 1'b0;
  logic [7:0] SData = 8'h00;
  logic [3:0] SColour = 4'h0;
  logic       LoadValid = 1'b0;
  logic       LoadReady;
  logic [3:0] PixelColour;
  logic       PixelValid;
  logic       Underrun;
  logic [7:0] UnderrunCount;

  logic       s_act = 1'b0;
  logic [7:0] s_dat = 8'h00;
  logic [3:0] s_colin = 4'h0;
  logic       s_lv = 1'b0;
  logic       s_rdy;
  logic [3:0] s_col;
  logic       s_vld;
  logic       s_unr;
  logic [1:0] s_cnt;

  int checks = 0;
  int errors = 0;

  semi_pixel_shifter #(.PIXEL_DIV(PD), .UNDERRUN_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .Active(Active), .SData(SData), .SColour(SColour),
    .LoadValid(LoadValid), .LoadReady(LoadReady), .PixelColour(PixelColour),
    .PixelValid(PixelValid), .Underrun(Underrun), .UnderrunCount(UnderrunCount)
  );

  semi_pixel_shifter #(.PIXEL_DIV(1), .UNDERRUN_W(2)) u_sat (
    .Clk(Clk), .Reset(Reset), .Active(s_act), .SData(s_dat), .SColour(s_colin),
    .LoadValid(s_lv), .LoadReady(s_rdy), .PixelColour(s_col),
    .PixelValid(s_vld), .Underrun(s_unr), .UnderrunCount(s_cnt)
  );

  always #5 Clk = ~Clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // Reference model: a holding slot plus the pixel index within the current character (-1 = none).
  int         m_div, m_pos, m_cnt;
  bit         m_full, m_vld, m_unr;
  logic [7:0] m_hd, m_cd;
  logic [3:0] m_hc, m_cc, m_col;

  task automatic model_reset();
    m_div = 0; m_pos = -1; m_cnt = 0;
    m_full = 0; m_vld = 0; m_unr = 0;
    m_hd = 0; m_cd = 0; m_hc = 0; m_cc = 0; m_col = 0;
  endtask

  task automatic model_step();
    bit accept;
    bit tick;
    accept = LoadValid && !m_full;
    tick   = Active && (m_div == PD - 1);
    m_unr  = 0;
    if (!Active) begin
      m_pos = -1; m_col = 0; m_vld = 0;
    end else if (tick) begin
      if (m_pos >= 0 && m_pos < 7) begin
        m_pos++;
      end else if (m_full) begin
        m_cd = m_hd; m_cc = m_hc; m_full = 0; m_pos = 0;
      end else begin
        if (m_pos == 7) begin
          m_unr = 1;
          if (m_cnt < 255) m_cnt++;
        end
        m_pos = -1;
      end
      m_vld = (m_pos >= 0);
      m_col = (m_pos >= 0 && m_cd[7 - m_pos]) ? m_cc : 4'h0;
    end
    m_div = Active ? (m_div + 1) % PD : 0;
    if (accept) begin
      m_full = 1; m_hd = SData; m_hc = SColour;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model on the edge, then compare every main-DUT output.
  // A sender withdraws LoadValid once its load has been taken.
  task automatic step();
    bit acc, s_acc;
    acc   = !Reset && LoadValid && LoadReady;
    s_acc = !Reset && s_lv && s_rdy;
    @(posedge Clk);
    if (Reset) model_reset(); else model_step();
    #1;
    if (acc) LoadValid = 1'b0;
    if (s_acc) s_lv = 1'b0;
    check("model_colour", PixelColour, m_col);
    check("model_valid", PixelValid, m_vld);
    check("model_underrun", Underrun, m_unr);
    check("model_ready", LoadReady, !m_full);
    check("model_count", UnderrunCount, m_cnt);
  endtask

  task automatic post(input logic [7:0] d, input logic [3:0] c);
    SData = d; SColour = c; LoadValid = 1'b1;
  endtask

  task automatic wait_vld(input string name, input int max);
    bit found;
    found = 0;
    for (int i = 0; i < max && !found; i++) begin
      step();
      found = PixelValid;
    end
    check(name, found, 1);
  endtask

  // Expects the first pixel of a character on screen now; pattern nibbles are left-to-right.
  task automatic sample(input string name, input logic [31:0] pat);
    logic [3:0] exp;
    for (int p = 0; p < 8; p++) begin
      exp = pat[31 - 4*p -: 4];
      check({name, "_colour"}, PixelColour, exp);
      check({name, "_valid"}, PixelValid, 1);
      check({name, "_no_underrun"}, Underrun, 0);
      repeat (PD) step();
    end
  endtask

  typedef struct {
    logic       act;
    logic       lv;
    logic [7:0] d;
    logic [3:0] c;
    logic [3:0] e_col;
    logic       e_vld;
    logic       e_unr;
    logic       e_rdy;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t tbl[19];

  initial begin
    bit found;

    // Single character 8'hA5 / 4'h3 from reset, PIXEL_DIV=2.
    tbl[0]  = '{1'b1, 1'b1, 8'hA5, 4'h3, 4'h0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{1'b1, 1'b0, 8'hA5, 4'h3, 4'h3, 1'b1, 1'b0, 1'b1, 8'd0};
    tbl[2]  = '{1'b1, 1'b0, 8'hA5, 4'h3, 4'h3, 1'b1, 1'b0, 1'b1, 8'd0};
    tbl[3]  = '{1'b1, 1'b0, 8'hA5, 4'h3, 4'h0, 1'b1, 1'b0, 1'b1, 8'd0};
    tbl[4]  = '{1'b1, 1'b0, 8'hA5, 4'h3, 4'h0, 1'b1, 1'b0, 1'b1, 8'd0};
    tbl[5]  = '{1'b1, 1'b0, 8'hA5, 4'h3, 4'h3, 1'b1, 1'b0, 1'b1, 8'd0};
    tbl[6]  = '{1'b1, 1'b0, 8'hA5, 4'h3, 4'h3, 1'b1, 1'b0, 1'b1, 8'd0};
    tbl[7]  = '{1'b1, 1'b0, 8'hA5, 4'h3, 4'h0, 1'b1, 1'b0, 1'b1, 8'd0};
    tbl[8]  = '{1'b1, 1'b0, 8'hA5, 4'h3, 4'h0, 1'b1, 1'b0, 1'b1, 8'd0};
    tbl[9]  = '{1'b1, 1'b0, 8'hA5, 4'h3, 4'h0, 1'b1, 1'b0, 1'b1, 8'd0};
    tbl[10] = '{1'b1, 1'b0, 8'hA5, 4'h3, 4'h0, 1'b1, 1'b0, 1'b1, 8'd0};
    tbl[11] = '{1'b1, 1'b0, 8'hA5, 4'h3, 4'h3, 1'b1, 1'b0, 1'b1, 8'd0};
    tbl[12] = '{1'b1, 1'b0, 8'hA5, 4'h3, 4'h3, 1'b1, 1'b0, 1'b1, 8'd0};
    tbl[13] = '{1'b1, 1'b0, 8'hA5, 4'h3, 4'h0, 1'b1, 1'b0, 1'b1, 8'd0};
    tbl[14] = '{1'b1, 1'b0, 8'hA5, 4'h3, 4'h0, 1'b1, 1'b0, 1'b1, 8'd0};
    tbl[15] = '{1'b1, 1'b0, 8'hA5, 4'h3, 4'h3, 1'b1, 1'b0, 1'b1, 8'd0};
    tbl[16] = '{1'b1, 1'b0, 8'hA5, 4'h3, 4'h3, 1'b1, 1'b0, 1'b1, 8'd0};
    tbl[17] = '{1'b1, 1'b0, 8'hA5, 4'h3, 4'h0, 1'b0, 1'b1, 1'b1, 8'd1};
    tbl[18] = '{1'b1, 1'b0, 8'hA5, 4'h3, 4'h0, 1'b0, 1'b0, 1'b1, 8'd1};

    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    check("reset_colour", PixelColour, 0);
    check("reset_valid", PixelValid, 0);
    check("reset_underrun", Underrun, 0);
    check("reset_ready", LoadReady, 1);
    check("reset_count", UnderrunCount, 0);
    Reset = 1'b0;

    for (int i = 0; i < 19; i++) begin
      Active = tbl[i].act; LoadValid = tbl[i].lv; SData = tbl[i].d; SColour = tbl[i].c;
      step();
      check($sformatf("tbl%0d_colour", i), PixelColour, tbl[i].e_col);
      check($sformatf("tbl%0d_valid", i), PixelValid, tbl[i].e_vld);
      check($sformatf("tbl%0d_underrun", i), Underrun, tbl[i].e_unr);
      check($sformatf("tbl%0d_ready", i), LoadReady, tbl[i].e_rdy);
      check($sformatf("tbl%0d_count", i), UnderrunCount, tbl[i].e_cnt);
    end

    // Back-to-back characters with the second offered as soon as the slot frees.
    post(8'hFF, 4'h5);
    step();
    post(8'h81, 4'hA);
    wait_vld("b2b_start", PD);
    sample("b2b_first", 32'h5555_5555);
    sample("b2b_second", 32'hA000_000A);

    // Prefetch during blanking, then release the display.
    Active = 1'b0;
    step();
    post(8'hF0, 4'h7);
    repeat (3) step();
    check("prefetch_blank_valid", PixelValid, 0);
    check("prefetch_held", LoadReady, 0);
    Active = 1'b1;
    wait_vld("prefetch_latency", PD);
    sample("prefetch", 32'h7777_0000);
    repeat (4) step();

    // Blanking mid-character with a character waiting in the holding register.
    post(8'hFF, 4'h2);
    wait_vld("drop_start", PD + 1);
    post(8'h3C, 4'h9);
    repeat (3 * PD) step();
    Active = 1'b0;
    step();
    check("drop_valid", PixelValid, 0);
    check("drop_no_underrun", Underrun, 0);
    check("drop_hold_kept", LoadReady, 0);
    repeat (2) step();
    Active = 1'b1;
    wait_vld("drop_resume", PD);
    sample("drop_resume", 32'h0099_9900);
    repeat (4) step();

    for (int i = 0; i < 800; i++) begin
      Active = ($urandom_range(0, 39) != 0);
      if (!LoadValid && $urandom_range(0, 2) == 0) post(8'($urandom), 4'($urandom));
      step();
    end

    // Saturating counter on the 2-bit instance.
    Active = 1'b0; LoadValid = 1'b0;
    s_act = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      s_dat = 8'h80; s_colin = 4'h1; s_lv = 1'b1;
      step();
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
        step();
        found = s_unr;
      end
      check($sformatf("sat%0d_pulse", k), found, 1);
      check($sformatf("sat%0d_count", k), s_cnt, (k < 3) ? k : 3);
      step();
      check($sformatf("sat%0d_pulse_width", k), s_unr, 0);
    end

    // Asynchronous reset in the middle of a character.
    Active = 1'b1;
    post(8'hFF, 4'h6);
    wait_vld("rst_start", PD + 1);
    post(8'h11, 4'h1);
    repeat (3) step();
    #2;
    Reset = 1'b1;
    #1;
    check("midrst_colour", PixelColour, 0);
    check("midrst_valid", PixelValid, 0);
    check("midrst_underrun", Underrun, 0);
    check("midrst_ready", LoadReady, 1);
    check("midrst_count", UnderrunCount, 0);
    check("midrst_sat_count", s_cnt, 0);
    LoadValid = 1'b0;
    Active = 1'b0;
    step();
    Reset = 1'b0;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
